// File: rtl/arbitrated_output_stage.sv
// rtl/arbitrated_output_stage.sv - grant capture into a 2-entry skid buffer with stall, tag and beat count
// Optional per-entry output parity: OUTPUT_PARITY_EN
module arbitrated_output_stage #(
  parameter int NUM_FIFOS = 4,
  parameter int WIDTH     = 8,
  parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
  parameter int CNTWIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_FIFOS-1:0] gnt,
  input  logic [WIDTH-1:0]    data_in,
  output logic                stall,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [TAGWIDTH-1:0] out_tag,
  output logic [CNTWIDTH-1:0] beat_count,
  output logic                err
`ifdef OUTPUT_PARITY_EN
  ,
  output logic                out_par
`endif
);

  logic [1:0]          occ;
  logic [1:0]          occ_next;
  logic [WIDTH-1:0]    head_data;
  logic [WIDTH-1:0]    skid_data;
  logic [TAGWIDTH-1:0] head_tag;
  logic [TAGWIDTH-1:0] skid_tag;
  logic [TAGWIDTH-1:0] cap_tag;
  logic                found;
  logic                gnt_any;
  logic                multi;
  logic                cap;
  logic                pop;

  assign gnt_any   = |gnt;
  assign multi     = |(gnt & (gnt - NUM_FIFOS'(1)));
  assign cap       = gnt_any && !stall;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = head_data;
  assign out_tag   = head_tag;

  // Lowest set grant bit wins when the arbiter misbehaves with a multi-hot vector
  always_comb begin
    cap_tag = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (gnt[i] && !found) begin
        cap_tag = TAGWIDTH'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    occ_next = occ;
    case (occ)
      2'd0: if (cap) occ_next = 2'd1;
      2'd1: begin
        if (cap && !pop) occ_next = 2'd2;
        else if (!cap && pop) occ_next = 2'd0;
      end
      2'd2: if (pop) occ_next = 2'd1;
      default: occ_next = 2'd0;
    endcase
  end

`ifdef OUTPUT_PARITY_EN
  logic head_par;
  logic skid_par;
  logic cap_par;

  assign cap_par = ^{cap_tag, data_in};
  assign out_par = head_par;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      occ        <= 2'd0;
      head_data  <= '0;
      head_tag   <= '0;
      skid_data  <= '0;
      skid_tag   <= '0;
      stall      <= 1'b0;
      beat_count <= '0;
      err        <= 1'b0;
`ifdef OUTPUT_PARITY_EN
      head_par   <= 1'b0;
      skid_par   <= 1'b0;
`endif
    end else begin
      occ   <= occ_next;
      stall <= (occ_next == 2'd2);
      if (pop) beat_count <= beat_count + CNTWIDTH'(1);
      if (gnt_any && (stall || multi)) err <= 1'b1;
      case (occ)
        2'd0: begin
          if (cap) begin
            head_data <= data_in;
            head_tag  <= cap_tag;
`ifdef OUTPUT_PARITY_EN
            head_par  <= cap_par;
`endif
          end
        end
        2'd1: begin
          // With a simultaneous pop the new beat takes over the head directly
          if (cap && pop) begin
            head_data <= data_in;
            head_tag  <= cap_tag;
`ifdef OUTPUT_PARITY_EN
            head_par  <= cap_par;
`endif
          end else if (cap) begin
            skid_data <= data_in;
            skid_tag  <= cap_tag;
`ifdef OUTPUT_PARITY_EN
            skid_par  <= cap_par;
`endif
          end
        end
        2'd2: begin
          if (pop) begin
            head_data <= skid_data;
            head_tag  <= skid_tag;
`ifdef OUTPUT_PARITY_EN
            head_par  <= skid_par;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/arbitrated_output_stage.md
Name: arbitrated_output_stage

Overview:
- Downstream consumer of the arbitrated FIFO block. Each cycle it captures the grant vector and the muxed FIFO head data.
- Records the source FIFO index as a binary tag.
- Buffers granted beats in a 2-entry skid buffer, presented to a valid/ready sink.
- Drives a registered stall back to the arbiter, which forces all grants low while the buffer is full.

Parameters:
- NUM_FIFOS, 4, number of arbitrated channels (gnt width).
- WIDTH, 8, data width.
- TAGWIDTH, $clog2(NUM_FIFOS), width of out_tag.
- CNTWIDTH, 16, width of the delivered-beat counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- gnt  input  NUM_FIFOS  one-hot grant from the arbiter; nonzero means a beat is popped this cycle.
- data_in  input  WIDTH  muxed FIFO head data, valid in the same cycle as gnt.
- stall  output  1  registered; when high, upstream must drive gnt == 0.
- out_valid  output  1  head entry valid.
- out_ready  input  1  sink accepts the head entry.
- out_data  output  WIDTH  head entry data.
- out_tag  output  TAGWIDTH  head entry source index.
- beat_count  output  CNTWIDTH  number of out_valid&out_ready handshakes since reset.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (sync, rst high at a posedge): occupancy = 0, out_valid = 0, out_data = 0, out_tag = 0, stall = 0, beat_count = 0, err = 0. Reset mid-operation discards all buffered entries. The outputs take these values in the cycle after the reset edge.
- Storage: head register plus skid register. Occupancy 0, 1 or 2. Order is strictly FIFO.
- Capture: capture occurs when gnt != 0 and stall == 0. The entry stores data_in and tag = index of the set gnt bit. If more than one bit is set, the lowest set index is used and err is set.
- Pop: pop occurs when out_valid && out_ready. Each pop increments beat_count, which wraps at 2^CNTWIDTH to 0.
- Occupancy transitions:
  - 0 with capture: entry goes to head. out_valid = 1 next cycle, giving 1-cycle latency from gnt to out_valid.
  - 1 with capture, no pop: entry goes to skid. Occupancy becomes 2.
  - 1 with capture and pop: new entry replaces head. Occupancy stays 1.
  - 1 with pop only: occupancy becomes 0.
  - 2 with pop: skid moves to head. Occupancy becomes 1.
  - 2 with no pop: hold.
- stall is registered and equals (next occupancy == 2). It rises the cycle after the skid fills and falls the cycle after a pop from occupancy 2.
- Protocol violation: gnt != 0 while stall == 1. The beat is dropped, err is set, and occupancy and data are unchanged.
- err is cleared only by rst.
- While out_valid && !out_ready, out_data and out_tag must hold stable.
- Content of invalid entries is don't-care.

Optional Feature:
- Macro: OUTPUT_PARITY_EN.
- Defined: adds output port out_par (1 bit), the even parity (XOR) of {out_tag, out_data}. out_par is stored per entry at capture, is 0 at reset, and moves with its entry through the skid buffer.
- Not defined: no out_par port; ports and behaviour are otherwise identical.

Test Plan:
- Reset, then gnt=4'b0100 with data_in=8'hA5 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_tag=2; following cycle out_valid=0, beat_count=1.
- out_ready=0; grants 0001/8'h11 then 1000/8'h22 on consecutive cycles -> stall=1 after the second; head=(11,0) held. Then out_ready=1 -> (11,0) then (22,3) delivered in order; stall=0 one cycle after the first pop.
- Occupancy 1 with simultaneous gnt=0010/8'h33 and pop -> occupancy stays 1; next head=(33,1); stall stays 0.
- Occupancy 2, stall=1, gnt=0001 asserted -> beat dropped, err=1 and sticky; buffered data unchanged.
- gnt=0110/8'h44 -> captured with out_tag=1, err=1. Then rst pulse for one cycle -> out_valid=0, err=0, beat_count=0, stall=0.
- CNTWIDTH=4: 17 back-to-back single-beat handshakes -> beat_count goes 15 -> 0 -> 1. With OUTPUT_PARITY_EN, data 8'h01, tag 0 -> out_par=1.
